// File: rtl/vdp_requant_nnbit.sv
// vdp_requant_nnbit: extracts a K-element dot product from a free-running MAC accumulator,
// then shifts, optionally ReLUs, saturates to N bits and holds it behind valid/ready.
module vdp_requant_nnbit #(
  parameter int N = 8,
  parameter int K = 3,
  parameter int SHIFT = 7,
  parameter int RELU = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic signed [2*N+K-2:0] acc,
  output logic                   busy,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic signed [N-1:0]    o,
  output logic                   sat
);
  localparam int W = 2*N+K-1;
  localparam int CW = $clog2(K+1);
  localparam logic signed [W-1:0] MAX_V = W'((1 << (N-1)) - 1);
  localparam logic signed [W-1:0] MIN_V = ~MAX_V;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt;
  logic signed [W-1:0] r_base, w_d, w_r, w_q;
  logic signed [N-1:0] w_o;
  logic w_load, w_cap, w_sat;
  always_comb begin
    w_state_n = r_state;
    w_load = 1'b0;
    w_cap = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_load = start;
        w_state_n = start ? RUN : IDLE;
      end
      RUN: begin
        w_cap = r_cnt == CW'(K);
        w_state_n = w_cap ? HOLD : RUN;
      end
      HOLD: begin
        w_load = o_ready & start;
        w_state_n = !o_ready ? HOLD : start ? RUN : IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end
  // modular difference stays exact across accumulator wrap since the frame sum fits in W bits
  always_comb begin
    w_d = acc - r_base;
    w_r = w_d >>> SHIFT;
    w_q = (RELU != 0 && w_r < 0) ? '0 : w_r;
    w_sat = (w_q > MAX_V) || (w_q < MIN_V);
    w_o = (w_q > MAX_V) ? MAX_V[N-1:0] : (w_q < MIN_V) ? MIN_V[N-1:0] : w_q[N-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_base <= '0;
      o <= '0;
      sat <= 1'b0;
      o_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      r_state <= w_state_n;
      busy <= w_state_n != IDLE;
      o_valid <= w_state_n == HOLD;
      if (w_load) begin
        r_base <= acc;
        r_cnt <= CW'(1);
      end else if (r_state == RUN && !w_cap) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap) begin
        o <= w_o;
        sat <= w_sat;
      end
    end
  end
endmodule

// File: tb/tb_vdp_requant_nnbit.sv
// tb_vdp_requant_nnbit: four parameter variants driven by a MAC model, checked against a frame-level model.
module tb_vdp_requant_nnbit;
  localparam int N = 8;
  localparam int K = 3;
  localparam int W = 2*N+K-1;
  logic clk = 0, rst = 1, start = 0, o_ready = 1, ld = 0, go = 0;
  logic signed [N-1:0] g = 0, e = 0;
  logic signed [W-1:0] acc = 0, ld_val = 0, gx, ex;
  logic [3:0] busy, valid, sat;
  logic signed [N-1:0] o [4];
  int checks = 0, errors = 0;
  assign gx = g;
  assign ex = e;
  always #5 clk = ~clk;
  always @(posedge clk) acc <= ld ? ld_val : acc + gx * ex;
  for (genvar i = 0; i < 4; i++) begin : g_dut
    vdp_requant_nnbit #(.N(N), .K(K), .SHIFT((i % 2) ? 0 : 7), .RELU(i / 2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .acc(acc), .busy(busy[i]),
      .o_valid(valid[i]), .o_ready(o_ready), .o(o[i]), .sat(sat[i]));
  end
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  function automatic void calc(input longint x, input int s, input bit relu,
                               output logic signed [N-1:0] q, output logic st);
    longint full, p, r;
    full = longint'(1) << W;
    if (x >= full / 2) x -= full;
    if (x < -(full / 2)) x += full;
    p = longint'(1) << s;
    r = x / p;
    if (x < 0 && x % p != 0) r -= 1;
    if (relu && r < 0) r = 0;
    st = 0;
    if (r > 127) begin r = 127; st = 1; end
    else if (r < -128) begin r = -128; st = 1; end
    q = N'(r);
  endfunction
  int left = 0;
  logic m_valid = 0;
  longint base = 0;
  logic signed [N-1:0] m_o [4];
  logic m_sat [4];
  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      m_valid = 0;
    end else if (m_valid) begin
      if (o_ready) begin
        m_valid = 0;
        if (start) begin left = K; base = acc; end
      end
    end else if (left == 1) begin
      left = 0;
      m_valid = 1;
      for (int i = 0; i < 4; i++) calc(longint'(acc) - base, (i % 2) ? 0 : 7, i / 2, m_o[i], m_sat[i]);
    end else if (left > 0) begin
      left--;
    end else if (start) begin
      left = K;
      base = acc;
    end
  end
  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("valid%0d", i), valid[i], m_valid);
        chk($sformatf("busy%0d", i), busy[i], m_valid || left > 0);
        if (m_valid) begin
          chk($sformatf("o%0d", i), o[i], m_o[i]);
          chk($sformatf("sat%0d", i), sat[i], m_sat[i]);
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic frame(input bit b, input logic [2:0] sm, input bit kill);
    int ga[3], ea[3];
    ga = '{29, 74, b ? 39 : -39};
    ea = '{b ? 38 : -38, b ? 91 : -91, 47};
    for (int j = 0; j < 3; j++) begin
      g = N'(ga[j]);
      e = N'(ea[j]);
      start = sm[j];
      rst = kill && j == 2;
      step(1);
    end
    g = 0; e = 0; start = 0; rst = 0;
  endtask
  task automatic res(input int o0, s0, o1, s1, o2, s2, o3, s3);
    chk("lit_o0", o[0], o0); chk("lit_sat0", sat[0], s0);
    chk("lit_o1", o[1], o1); chk("lit_sat1", sat[1], s1);
    chk("lit_o2", o[2], o2); chk("lit_sat2", sat[2], s2);
    chk("lit_o3", o[3], o3); chk("lit_sat3", sat[3], s3);
  endtask
  task automatic zeros(input string nm);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_busy"}, busy[i], 0); chk({nm, "_valid"}, valid[i], 0);
      chk({nm, "_o"}, o[i], 0); chk({nm, "_sat"}, sat[i], 0);
    end
  endtask
  initial begin
    step(2);
    rst = 0;
    go = 1;
    zeros("reset");
    frame(0, 3'b001, 0);
    chk("basic_early_valid", valid[0], 0);
    chk("basic_busy", busy[0], 1);
    step(1);
    chk("basic_valid", valid[0], 1);
    res(-76, 0, -128, 1, 0, 0, 0, 0);
    step(1);
    chk("basic_valid_drop", valid[0], 0);
    chk("basic_busy_drop", busy[0], 0);
    o_ready = 0;
    frame(0, 3'b001, 0);
    step(1);
    for (int c = 0; c < 4; c++) begin
      start = c == 1;
      chk("stall_valid", valid[0], 1);
      chk("stall_o", o[0], -76);
      step(1);
    end
    start = 0;
    o_ready = 1;
    frame(1, 3'b001, 0);
    step(1);
    chk("b2b_valid", valid[0], 1);
    res(75, 0, 127, 1, 75, 0, 127, 1);
    step(1);
    frame(0, 3'b011, 0);
    step(1);
    chk("ign_valid", valid[0], 1);
    res(-76, 0, -128, 1, 0, 0, 0, 0);
    step(1);
    ld = 1;
    ld_val = 18'sd130971;
    step(1);
    ld = 0;
    frame(1, 3'b001, 0);
    chk("wrap_acc_neg", acc < 0, 1);
    step(1);
    res(75, 0, 127, 1, 75, 0, 127, 1);
    step(1);
    frame(0, 3'b001, 1);
    zeros("midrst");
    step(3);
    chk("midrst_novalid", valid[0], 0);
    frame(0, 3'b001, 0);
    step(1);
    chk("after_rst_valid", valid[0], 1);
    res(-76, 0, -128, 1, 0, 0, 0, 0);
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
